// File: rtl/sv8000_input_matrix.sv
// -----------------------------------------------------------------------------
// sv8000_input_matrix
//
// Turns MiSTer joystick words and PS/2 key events into the SuperVision 8000
// controller key matrix. The console drives an active-low column strobe and
// reads back one active-low row byte per controller.
//
// Parameters
//   KB_PLAYER    controller (0 or 1) that PS/2 keys are merged into
//   SOCD_FILTER  1: opposing directions held together both read as released
//
// Ports
//   clk_sys    in   1   system clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   joy0       in  32   player 1 joystick word (bits 17:0 used, active high)
//   joy1       in  32   player 2 joystick word, same layout
//   ps2_key    in  11   [10] toggle, [9] press, [8] extended, [7:0] scancode
//   col_sel_n  in   4   column strobe, active low, several may be low
//   row0_n     out  8   controller 0 row byte, active low, registered
//   row1_n     out  8   controller 1 row byte, active low, registered
//   kb_active  out  1   high while any tracked PS/2 key is held
//
// Key vector bit order (both joystick and keyboard):
//   0 right, 1 left, 2 down, 3 up, 4 Fire1, 5 Fire2,
//   6..14 keys 1..9, 15 key 0, 16 '*', 17 '#'
// -----------------------------------------------------------------------------
module sv8000_input_matrix #(
    parameter int KB_PLAYER   = 0,
    parameter bit SOCD_FILTER = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [31:0] joy0,
    input  logic [31:0] joy1,
    input  logic [10:0] ps2_key,
    input  logic [3:0]  col_sel_n,
    output logic [7:0]  row0_n,
    output logic [7:0]  row1_n,
    output logic        kb_active
);

    // One-hot key-vector mask for a scancode; all zeros when the code is
    // unmapped or carries the wrong extended flag.
    function automatic logic [17:0] key_mask(input logic ext, input logic [7:0] code);
        logic [17:0] m;
        m = 18'd0;
        if (ext) begin
            case (code)
                8'h75:   m[3] = 1'b1;
                8'h72:   m[2] = 1'b1;
                8'h6B:   m[1] = 1'b1;
                8'h74:   m[0] = 1'b1;
                default: m = 18'd0;
            endcase
        end else begin
            case (code)
                8'h14:   m[4]  = 1'b1;
                8'h11:   m[5]  = 1'b1;
                8'h16:   m[6]  = 1'b1;
                8'h1E:   m[7]  = 1'b1;
                8'h26:   m[8]  = 1'b1;
                8'h25:   m[9]  = 1'b1;
                8'h2E:   m[10] = 1'b1;
                8'h36:   m[11] = 1'b1;
                8'h3D:   m[12] = 1'b1;
                8'h3E:   m[13] = 1'b1;
                8'h46:   m[14] = 1'b1;
                8'h45:   m[15] = 1'b1;
                8'h7C:   m[16] = 1'b1;
                8'h5D:   m[17] = 1'b1;
                default: m = 18'd0;
            endcase
        end
        return m;
    endfunction

    // Opposing-direction cleanup: up+down and left+right each cancel out.
    function automatic logic [17:0] apply_socd(input logic [17:0] k);
        logic [17:0] f;
        f = k;
        if (SOCD_FILTER && k[3] && k[2]) begin
            f[3:2] = 2'b00;
        end else begin
            f[3:2] = k[3:2];
        end
        if (SOCD_FILTER && k[1] && k[0]) begin
            f[1:0] = 2'b00;
        end else begin
            f[1:0] = k[1:0];
        end
        return f;
    endfunction

    // Active-low row byte for the selected columns. Column 3 has no keys,
    // so selecting it never pulls a row low.
    function automatic logic [7:0] row_byte(input logic [17:0] k, input logic [2:0] cs_n);
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] c2;
        logic [7:0] r;
        c0 = {2'b11, ~k[5], ~k[4], ~k[0], ~k[1], ~k[2], ~k[3]};
        c1 = {2'b11, ~k[11:6]};
        c2 = {2'b11, ~k[17:12]};
        r  = 8'hFF;
        if (!cs_n[0]) begin
            r = r & c0;
        end else begin
            r = r;
        end
        if (!cs_n[1]) begin
            r = r & c1;
        end else begin
            r = r;
        end
        if (!cs_n[2]) begin
            r = r & c2;
        end else begin
            r = r;
        end
        return r;
    endfunction

    logic        r_tog;
    logic        r_armed;
    logic [17:0] r_kb;
    logic [7:0]  r_row0;
    logic [7:0]  r_row1;
    logic        r_kb_active;

    logic        w_event;
    logic [17:0] w_mask;
    logic [17:0] w_kb_next;
    logic [17:0] w_key0;
    logic [17:0] w_key1;
    logic        w_unused_bits;

    assign w_unused_bits = ^{joy0[31:18], joy1[31:18], col_sel_n[3]};

    // r_armed is low on the first clock after reset so that a toggle input
    // sitting at 1 is loaded silently instead of looking like an event.
    assign w_event = r_armed & (r_tog ^ ps2_key[10]);
    assign w_mask  = key_mask(ps2_key[8], ps2_key[7:0]);

    // Keyboard state after applying the current event, if any.
    always_comb begin
        w_kb_next = r_kb;
        if (w_event) begin
            if (ps2_key[9]) begin
                w_kb_next = r_kb | w_mask;
            end else begin
                w_kb_next = r_kb & ~w_mask;
            end
        end else begin
            w_kb_next = r_kb;
        end
    end

    // Merge keyboard into the selected player, then filter directions.
    always_comb begin
        w_key0 = joy0[17:0];
        w_key1 = joy1[17:0];
        if (KB_PLAYER == 0) begin
            w_key0 = apply_socd(joy0[17:0] | r_kb);
            w_key1 = apply_socd(joy1[17:0]);
        end else begin
            w_key0 = apply_socd(joy0[17:0]);
            w_key1 = apply_socd(joy1[17:0] | r_kb);
        end
    end

    // Toggle tracking, keyboard state and registered matrix outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_tog       <= 1'b0;
            r_armed     <= 1'b0;
            r_kb        <= 18'd0;
            r_row0      <= 8'hFF;
            r_row1      <= 8'hFF;
            r_kb_active <= 1'b0;
        end else begin
            r_tog       <= ps2_key[10];
            r_armed     <= 1'b1;
            r_kb        <= w_kb_next;
            r_row0      <= row_byte(w_key0, col_sel_n[2:0]);
            r_row1      <= row_byte(w_key1, col_sel_n[2:0]);
            r_kb_active <= |w_kb_next;
        end
    end

    assign row0_n    = r_row0;
    assign row1_n    = r_row1;
    assign kb_active = r_kb_active;

endmodule

// File: tb/tb_sv8000_input_matrix.sv
// -----------------------------------------------------------------------------
// Bench for sv8000_input_matrix. Two instances share all inputs:
//   dut_a: KB_PLAYER=0, SOCD_FILTER=1
//   dut_b: KB_PLAYER=1, SOCD_FILTER=0
// A key-table model computes the expected rows every cycle; directed
// scenarios add literal expectations, then a randomized run follows.
// -----------------------------------------------------------------------------
module tb_sv8000_input_matrix;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [31:0] joy0;
    logic [31:0] joy1;
    logic [10:0] ps2_key;
    logic [3:0]  col_sel_n;
    logic [7:0]  row0_a, row1_a, row0_b, row1_b;
    logic        kb_active_a, kb_active_b;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    always #5 clk_sys = ~clk_sys;

    sv8000_input_matrix #(.KB_PLAYER(0), .SOCD_FILTER(1'b1)) dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .joy0(joy0), .joy1(joy1),
        .ps2_key(ps2_key), .col_sel_n(col_sel_n),
        .row0_n(row0_a), .row1_n(row1_a), .kb_active(kb_active_a)
    );

    sv8000_input_matrix #(.KB_PLAYER(1), .SOCD_FILTER(1'b0)) dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .joy0(joy0), .joy1(joy1),
        .ps2_key(ps2_key), .col_sel_n(col_sel_n),
        .row0_n(row0_b), .row1_n(row1_b), .kb_active(kb_active_b)
    );

    // ---------------- reference model ----------------
    function automatic int key_index(input logic ext, input logic [7:0] code);
        if (ext) begin
            case (code)
                8'h75: return 3;
                8'h72: return 2;
                8'h6B: return 1;
                8'h74: return 0;
                default: return -1;
            endcase
        end else begin
            case (code)
                8'h14: return 4;   8'h11: return 5;
                8'h16: return 6;   8'h1E: return 7;   8'h26: return 8;
                8'h25: return 9;   8'h2E: return 10;  8'h36: return 11;
                8'h3D: return 12;  8'h3E: return 13;  8'h46: return 14;
                8'h45: return 15;  8'h7C: return 16;  8'h5D: return 17;
                default: return -1;
            endcase
        end
    endfunction

    function automatic logic [17:0] next_kb(input logic [17:0] kb, input logic [10:0] key);
        int idx;
        logic [17:0] n;
        idx = key_index(key[8], key[7:0]);
        n = kb;
        if (idx >= 0) n[idx] = key[9];
        return n;
    endfunction

    function automatic logic [17:0] merge(input logic [31:0] joy, input logic [17:0] kb,
                                          input bit use_kb, input bit socd);
        logic [17:0] k;
        k = joy[17:0] | (use_kb ? kb : 18'd0);
        if (socd) begin
            if (k[3] && k[2]) begin k[3] = 1'b0; k[2] = 1'b0; end
            if (k[1] && k[0]) begin k[1] = 1'b0; k[0] = 1'b0; end
        end
        return k;
    endfunction

    // Column 0 rows 0..3 are up,down,left,right = key bits 3,2,1,0; rows 4,5
    // are bits 4,5. Columns 1 and 2 hold key bits 6..11 and 12..17.
    function automatic logic [7:0] exp_row(input logic [17:0] k, input logic [3:0] cs_n);
        logic [7:0] r;
        int idx;
        r = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            if (!cs_n[c]) begin
                for (int row = 0; row < 6; row++) begin
                    if (c == 0) idx = (row < 4) ? (3 - row) : row;
                    else        idx = 6 * c + row;
                    if (k[idx]) r[row] = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [17:0] m_kb;
    logic        m_tog;
    logic        m_armed;
    logic [7:0]  m_row0a, m_row1a, m_row0b, m_row1b;

    // Model state: expected rows from pre-edge inputs, then apply any event.
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            m_kb    <= 18'd0;
            m_tog   <= 1'b0;
            m_armed <= 1'b0;
            m_row0a <= 8'hFF; m_row1a <= 8'hFF;
            m_row0b <= 8'hFF; m_row1b <= 8'hFF;
        end else begin
            m_row0a <= exp_row(merge(joy0, m_kb, 1'b1, 1'b1), col_sel_n);
            m_row1a <= exp_row(merge(joy1, m_kb, 1'b0, 1'b1), col_sel_n);
            m_row0b <= exp_row(merge(joy0, m_kb, 1'b0, 1'b0), col_sel_n);
            m_row1b <= exp_row(merge(joy1, m_kb, 1'b1, 1'b0), col_sel_n);
            if (m_armed && (ps2_key[10] !== m_tog)) m_kb <= next_kb(m_kb, ps2_key);
            m_tog   <= ps2_key[10];
            m_armed <= 1'b1;
        end
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk_sys) begin
        if (check_en) begin
            check8("row0_a", row0_a, m_row0a);
            check8("row1_a", row1_a, m_row1a);
            check8("row0_b", row0_b, m_row0b);
            check8("row1_b", row1_b, m_row1b);
            check8("kb_active_a", {7'd0, kb_active_a}, {7'd0, |m_kb});
            check8("kb_active_b", {7'd0, kb_active_b}, {7'd0, |m_kb});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_sys);
        #3;
    endtask

    task automatic ps2_event(input bit press, input bit ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], press, ext, code};
    endtask

    logic [7:0] codes [20] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                               8'h3E, 8'h46, 8'h45, 8'h7C, 8'h5D, 8'h14, 8'h11,
                               8'h1C, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74};

    initial begin
        int ci;
        reset_n   = 1'b0;
        joy0      = 32'd0;
        joy1      = 32'd0;
        ps2_key   = 11'd0;
        col_sel_n = 4'b0000;
        step();
        step();
        check8("rst_row0_a", row0_a, 8'hFF);
        check8("rst_kb_active_a", {7'd0, kb_active_a}, 8'd0);
        reset_n  = 1'b1;
        check_en = 1'b1;
        step();
        step();
        check8("idle_row0_a", row0_a, 8'hFF);
        check8("idle_row1_a", row1_a, 8'hFF);
        check8("idle_kb_active_a", {7'd0, kb_active_a}, 8'd0);

        // Fire1 on player 2, column 0.
        joy1 = 32'h0000_0010;
        col_sel_n = 4'b1110;
        step();
        check8("fire1_row1_a", row1_a, 8'hEF);
        check8("fire1_row0_a", row0_a, 8'hFF);
        check8("model_fire1", m_row1a, 8'hEF);
        joy1 = 32'd0;
        col_sel_n = 4'b1101;
        step();

        // PS/2 key 1 press then release.
        ps2_event(1'b1, 1'b0, 8'h16);
        step();
        check8("k1_kb_active_a", {7'd0, kb_active_a}, 8'd1);
        check8("k1_row0_a_early", row0_a, 8'hFF);
        step();
        check8("k1_row0_a", row0_a, 8'hFE);
        check8("k1_row1_b", row1_b, 8'hFE);
        check8("model_k1", m_row0a, 8'hFE);
        ps2_event(1'b0, 1'b0, 8'h16);
        step();
        step();
        check8("k1_rel_row0_a", row0_a, 8'hFF);
        check8("k1_rel_kb_active_a", {7'd0, kb_active_a}, 8'd0);

        // Up from keyboard plus down from joystick.
        col_sel_n = 4'b1110;
        joy0 = 32'h0000_0004;
        joy1 = 32'h0000_0004;
        ps2_event(1'b1, 1'b1, 8'h75);
        step();
        step();
        check8("socd_row0_a", row0_a, 8'hFF);
        check8("nosocd_row1_b", row1_b, 8'hFC);
        check8("down_row0_b", row0_b, 8'hFD);
        check8("model_nosocd", m_row1b, 8'hFC);
        ps2_event(1'b0, 1'b1, 8'h75);
        joy0 = 32'd0;
        joy1 = 32'd0;
        step();
        step();

        // Key 1 and '#' with columns 1 and 2.
        joy0 = 32'h0002_0040;
        col_sel_n = 4'b1001;
        step();
        check8("cols12_row0_a", row0_a, 8'hDE);
        joy0 = 32'd0;

        // Wrong extended flag, then a release of a key not held.
        ps2_event(1'b1, 1'b1, 8'h16);
        step();
        step();
        check8("wrong_ext_kb_active_a", {7'd0, kb_active_a}, 8'd0);
        ps2_event(1'b0, 1'b0, 8'h26);
        step();
        step();
        check8("stray_rel_kb_active_a", {7'd0, kb_active_a}, 8'd0);

        // Typematic repeats of key 2 leave it held.
        col_sel_n = 4'b1101;
        ps2_event(1'b1, 1'b0, 8'h1E);
        step();
        ps2_event(1'b1, 1'b0, 8'h1E);
        step();
        ps2_event(1'b1, 1'b0, 8'h1E);
        step();
        step();
        check8("typematic_row0_a", row0_a, 8'hFD);
        check8("typematic_kb_active_a", {7'd0, kb_active_a}, 8'd1);

        // Reset while key 2 is held; toggle input stays at 1.
        reset_n = 1'b0;
        #1;
        check8("midrst_kb_active_a", {7'd0, kb_active_a}, 8'd0);
        check8("midrst_row0_a", row0_a, 8'hFF);
        step();
        reset_n = 1'b1;
        step();
        step();
        check8("postrst_kb_active_a", {7'd0, kb_active_a}, 8'd0);
        check8("postrst_row0_a", row0_a, 8'hFF);

        // Randomized run.
        for (int i = 0; i < 3000; i++) begin
            joy0      = $urandom & $urandom;
            joy1      = $urandom & $urandom;
            col_sel_n = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                ci = $urandom_range(0, 19);
                ps2_event(1'($urandom_range(0, 1)),
                          (ci >= 16) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 4) == 0),
                          codes[ci]);
            end
            if ($urandom_range(0, 399) == 0) begin
                reset_n = 1'b0;
                step();
                reset_n = 1'b1;
            end
            step();
        end

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
